// File: rtl/tx_buf_pkg.sv
// Shared types and helpers for the TX FrameLink buffer reader.
package tx_buf_pkg;

  // Wide enough to hold the last-byte index for any supported data width (up to 128 bits).
  localparam int REM_WIDTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2
  } rd_state_e;

  // log2 of bytes per word; data widths are restricted to 32/64/128.
  function automatic int unsigned word_shift(input int unsigned data_width);
    case (data_width)
      32:      return 2;
      128:     return 4;
      default: return 3;
    endcase
  endfunction

  // ceil(len / bytes_per_word) using a mask-and-shift instead of a divider.
  function automatic logic [31:0] bytes_to_words(input logic [31:0] len,
                                                 input int unsigned data_width);
    logic [31:0] mask;
    mask = (32'd1 << word_shift(data_width)) - 32'd1;
    return (len + mask) >> word_shift(data_width);
  endfunction

  // Index of the last valid byte in the final word: (len-1) mod bytes_per_word.
  function automatic logic [REM_WIDTH-1:0] last_rem(input logic [31:0] len,
                                                    input int unsigned data_width);
    logic [31:0] mask;
    mask = (32'd1 << word_shift(data_width)) - 32'd1;
    return REM_WIDTH'((len - 32'd1) & mask);
  endfunction

endpackage

// File: rtl/tx_fl_skid_fifo.sv
// Two-entry FIFO between the RAM read port and the FrameLink output.
// The caller only pushes when a slot is guaranteed (read credit), so a push
// into a full FIFO only ever coincides with a pop.
module tx_fl_skid_fifo #(
  parameter int DATA_WIDTH = 64,
  parameter int REM_W      = 3
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] push_data_i,
  input  logic                  push_first_i,
  input  logic                  push_last_i,
  input  logic [REM_W-1:0]      push_rem_i,
  input  logic                  pop_i,
  output logic [DATA_WIDTH-1:0] head_data_o,
  output logic                  head_first_o,
  output logic                  head_last_o,
  output logic [REM_W-1:0]      head_rem_o,
  output logic [1:0]            count_o
);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic                  first;
    logic                  last;
    logic [REM_W-1:0]      rem;
  } entry_t;

  entry_t     mem_q [2];
  logic       wr_ptr_q;
  logic       rd_ptr_q;
  logic [1:0] count_q;
  logic       do_pop;

  assign do_pop = pop_i && (count_q != 2'd0);

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push_i) wr_ptr_q <= ~wr_ptr_q;
      if (do_pop) rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_q + {1'b0, push_i} - {1'b0, do_pop};
    end
  end

  // Entry storage; contents are only meaningful while counted as occupied.
  always_ff @(posedge CLK) begin
    if (push_i) begin
      mem_q[wr_ptr_q] <= '{data: push_data_i, first: push_first_i,
                           last: push_last_i, rem: push_rem_i};
    end
  end

  assign head_data_o  = mem_q[rd_ptr_q].data;
  assign head_first_o = mem_q[rd_ptr_q].first;
  assign head_last_o  = mem_q[rd_ptr_q].last;
  assign head_rem_o   = mem_q[rd_ptr_q].rem;
  assign count_o      = count_q;

endmodule

// File: rtl/tx_fl_buf_reader.sv
// Reads committed frames out of the circular TX buffer RAM, emits them as
// single-part FrameLink and returns the consumed space to the writer.
module tx_fl_buf_reader
  import tx_buf_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int BLOCK_SIZE = 512,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                                  CLK,
  input  logic                                  RESET,
  input  logic                                  FRAME_VLD,
  output logic                                  FRAME_RDY,
  input  logic [$clog2(BLOCK_SIZE)-1:0]         FRAME_ADDR,
  input  logic [LEN_WIDTH-1:0]                  FRAME_LEN,
  output logic                                  BUF_RD,
  output logic [$clog2(BLOCK_SIZE)-1:0]         BUF_ADDR,
  input  logic [DATA_WIDTH-1:0]                 BUF_DO,
  output logic [DATA_WIDTH-1:0]                 TX_DATA,
  output logic                                  TX_SOF_N,
  output logic                                  TX_SOP_N,
  output logic                                  TX_EOP_N,
  output logic                                  TX_EOF_N,
  output logic [$clog2(DATA_WIDTH/8)-1:0]       TX_REM,
  output logic                                  TX_SRC_RDY_N,
  input  logic                                  TX_DST_RDY_N,
  output logic                                  REL_VLD,
  output logic [$clog2(BLOCK_SIZE):0]           REL_WORDS,
  output logic                                  BUSY,
  output logic [31:0]                           FRAMES_SENT
);

  localparam int AW = $clog2(BLOCK_SIZE);
  localparam int RW = $clog2(DATA_WIDTH/8);
  localparam int WW = AW + 1;

  rd_state_e       state_q, state_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [WW-1:0]   words_q, words_d;
  logic [WW-1:0]   remain_q, remain_d;
  logic [RW-1:0]   lrem_q, lrem_d;
  logic            rel_vld_q, rel_vld_d;
  logic [WW-1:0]   rel_words_q, rel_words_d;
  logic [31:0]     frames_q, frames_d;

  // Read tags travel one cycle behind the strobe to meet the RAM data.
  logic            rd_pend_q;
  logic            tag_first_q, tag_last_q;
  logic [RW-1:0]   tag_rem_q;

  logic            frame_rdy, buf_rd;
  logic [WW-1:0]   frm_words;
  logic [RW-1:0]   frm_rem;

  logic [DATA_WIDTH-1:0] head_data;
  logic            head_first, head_last;
  logic [RW-1:0]   head_rem;
  logic [1:0]      fifo_cnt;
  logic            tx_vld, tx_xfer, rd_credit;
  logic [2:0]      free_slots;

  assign frm_words = WW'(bytes_to_words(32'(FRAME_LEN), DATA_WIDTH));
  assign frm_rem   = RW'(last_rem(32'(FRAME_LEN), DATA_WIDTH));

  assign tx_vld  = (fifo_cnt != 2'd0);
  assign tx_xfer = tx_vld && !TX_DST_RDY_N;

  // A slot popped this cycle counts as free, which is what sustains one word per cycle.
  assign free_slots = 3'd2 - {1'b0, fifo_cnt} + {2'b0, tx_xfer};
  assign rd_credit  = free_slots > {2'b0, rd_pend_q};

  // Next-state, read issue and release generation.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    words_d     = words_q;
    remain_d    = remain_q;
    lrem_d      = lrem_q;
    rel_vld_d   = 1'b0;
    rel_words_d = rel_words_q;
    frames_d    = frames_q;
    frame_rdy   = 1'b0;
    buf_rd      = 1'b0;
    if (!RESET) begin
      case (state_q)
        ST_IDLE: begin
          frame_rdy = 1'b1;
          if (FRAME_VLD) begin
            addr_d   = FRAME_ADDR;
            words_d  = frm_words;
            remain_d = frm_words;
            lrem_d   = frm_rem;
            if (FRAME_LEN == '0) begin
              // Empty frame: nothing to send, release zero words straight away.
              rel_vld_d   = 1'b1;
              rel_words_d = '0;
            end else begin
              state_d = ST_READ;
            end
          end
        end
        ST_READ: begin
          if (rd_credit) begin
            buf_rd   = 1'b1;
            addr_d   = addr_q + AW'(1);
            remain_d = remain_q - WW'(1);
            if (remain_q == WW'(1)) state_d = ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (tx_xfer && head_last) begin
            state_d     = ST_IDLE;
            rel_vld_d   = 1'b1;
            rel_words_d = words_q;
            frames_d    = frames_q + 32'd1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Control state registers.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      words_q     <= '0;
      remain_q    <= '0;
      lrem_q      <= '0;
      rel_vld_q   <= 1'b0;
      rel_words_q <= '0;
      frames_q    <= '0;
      rd_pend_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      words_q     <= words_d;
      remain_q    <= remain_d;
      lrem_q      <= lrem_d;
      rel_vld_q   <= rel_vld_d;
      rel_words_q <= rel_words_d;
      frames_q    <= frames_d;
      rd_pend_q   <= buf_rd;
    end
  end

  // First/last/REM tags captured at read issue, qualified by rd_pend_q.
  always_ff @(posedge CLK) begin
    tag_first_q <= (remain_q == words_q);
    tag_last_q  <= (remain_q == WW'(1));
    tag_rem_q   <= (remain_q == WW'(1)) ? lrem_q : '1;
  end

  tx_fl_skid_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .REM_W      (RW)
  ) u_skid (
    .CLK          (CLK),
    .RESET        (RESET),
    .push_i       (rd_pend_q),
    .push_data_i  (BUF_DO),
    .push_first_i (tag_first_q),
    .push_last_i  (tag_last_q),
    .push_rem_i   (tag_rem_q),
    .pop_i        (tx_xfer),
    .head_data_o  (head_data),
    .head_first_o (head_first),
    .head_last_o  (head_last),
    .head_rem_o   (head_rem),
    .count_o      (fifo_cnt)
  );

  assign FRAME_RDY    = frame_rdy;
  assign BUF_RD       = buf_rd;
  assign BUF_ADDR     = addr_q;
  assign TX_SRC_RDY_N = ~tx_vld;
  assign TX_DATA      = tx_vld ? head_data : '0;
  assign TX_REM       = tx_vld ? head_rem : '0;
  assign TX_SOF_N     = ~(tx_vld && head_first);
  assign TX_SOP_N     = ~(tx_vld && head_first);
  assign TX_EOF_N     = ~(tx_vld && head_last);
  assign TX_EOP_N     = ~(tx_vld && head_last);
  assign REL_VLD      = rel_vld_q;
  assign REL_WORDS    = rel_words_q;
  assign BUSY         = (state_q != ST_IDLE);
  assign FRAMES_SENT  = frames_q;

endmodule

// File: tb/tb_tx_fl_buf_reader.sv
// Directed and randomized bench for tx_fl_buf_reader (64-bit data, 512-word buffer).
module tb_tx_fl_buf_reader;

  localparam int DW = 64;
  localparam int BS = 512;
  localparam int LW = 16;
  localparam int AW = 9;
  localparam int RW = 3;
  localparam int WW = 10;

  logic          CLK, RESET;
  logic          FRAME_VLD, FRAME_RDY;
  logic [AW-1:0] FRAME_ADDR;
  logic [LW-1:0] FRAME_LEN;
  logic          BUF_RD;
  logic [AW-1:0] BUF_ADDR;
  logic [DW-1:0] BUF_DO;
  logic [DW-1:0] TX_DATA;
  logic          TX_SOF_N, TX_SOP_N, TX_EOP_N, TX_EOF_N;
  logic [RW-1:0] TX_REM;
  logic          TX_SRC_RDY_N, TX_DST_RDY_N;
  logic          REL_VLD;
  logic [WW-1:0] REL_WORDS;
  logic          BUSY;
  logic [31:0]   FRAMES_SENT;

  tx_fl_buf_reader #(.DATA_WIDTH(DW), .BLOCK_SIZE(BS), .LEN_WIDTH(LW)) dut (
    .CLK(CLK), .RESET(RESET),
    .FRAME_VLD(FRAME_VLD), .FRAME_RDY(FRAME_RDY),
    .FRAME_ADDR(FRAME_ADDR), .FRAME_LEN(FRAME_LEN),
    .BUF_RD(BUF_RD), .BUF_ADDR(BUF_ADDR), .BUF_DO(BUF_DO),
    .TX_DATA(TX_DATA), .TX_SOF_N(TX_SOF_N), .TX_SOP_N(TX_SOP_N),
    .TX_EOP_N(TX_EOP_N), .TX_EOF_N(TX_EOF_N), .TX_REM(TX_REM),
    .TX_SRC_RDY_N(TX_SRC_RDY_N), .TX_DST_RDY_N(TX_DST_RDY_N),
    .REL_VLD(REL_VLD), .REL_WORDS(REL_WORDS), .BUSY(BUSY),
    .FRAMES_SENT(FRAMES_SENT)
  );

  int n_vec  = 0;
  int n_miss = 0;

  logic [DW-1:0] mem [BS];

  typedef struct packed {
    logic [DW-1:0] data;
    logic          sof, sop, eof, eop;
    logic [RW-1:0] rem;
  } beat_t;

  typedef struct {
    logic [AW-1:0] addr;
    logic [LW-1:0] len;
    int            words;
    logic [RW-1:0] rem;
    bit            stall;
  } vec_t;

  beat_t         beats[$];
  logic [AW-1:0] rd_addrs[$];
  int            rel_count = 0;
  logic [WW-1:0] last_rel_words = '0;
  longint        rel_sum = 0;
  bit            stall_en = 1'b0;
  logic          prev_stall = 1'b0;
  beat_t         prev_beat = '0;
  int            exp_frames = 0;
  vec_t          vecs[7];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic beat_t cur_beat();
    beat_t b;
    b.data = TX_DATA;
    b.sof  = ~TX_SOF_N;
    b.sop  = ~TX_SOP_N;
    b.eof  = ~TX_EOF_N;
    b.eop  = ~TX_EOP_N;
    b.rem  = TX_REM;
    return b;
  endfunction

  function automatic logic [6:0] ctl_of(input beat_t b);
    return {b.sof, b.sop, b.eof, b.eop, b.rem};
  endfunction

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Synchronous RAM model: data valid one cycle after the read strobe.
  always @(posedge CLK) begin
    if (BUF_RD) BUF_DO <= mem[BUF_ADDR];
  end

  // Sink back-pressure: about 60% busy when stalls are enabled.
  initial begin
    TX_DST_RDY_N = 1'b0;
    forever begin
      @(posedge CLK);
      #1;
      TX_DST_RDY_N = (stall_en && ($urandom_range(0, 99) < 60)) ? 1'b1 : 1'b0;
    end
  end

  // Interface monitor: logs reads, transfers and releases; checks hold while stalled.
  always @(negedge CLK) begin
    if (RESET) begin
      prev_stall <= 1'b0;
    end else begin
      if (BUF_RD) rd_addrs.push_back(BUF_ADDR);
      if (!TX_SRC_RDY_N && !TX_DST_RDY_N) beats.push_back(cur_beat());
      if (REL_VLD) begin
        rel_count      <= rel_count + 1;
        last_rel_words <= REL_WORDS;
        rel_sum        <= rel_sum + longint'(REL_WORDS);
      end
      if (prev_stall) begin
        chk("hold_src_rdy", 64'(TX_SRC_RDY_N), 64'd0);
        chk("hold_data", TX_DATA, prev_beat.data);
        chk("hold_ctl", 64'(ctl_of(cur_beat())), 64'(ctl_of(prev_beat)));
      end
      prev_stall <= !TX_SRC_RDY_N && TX_DST_RDY_N;
      prev_beat  <= cur_beat();
    end
  end

  task automatic recover();
    RESET = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    RESET = 1'b0;
    exp_frames = 0;
  endtask

  task automatic commit(input logic [AW-1:0] a, input logic [LW-1:0] l);
    int t;
    t = 0;
    @(negedge CLK);
    while (!FRAME_RDY && t < 100) begin
      @(negedge CLK);
      t++;
    end
    chk("frame_rdy_wait", 64'(FRAME_RDY), 64'd1);
    FRAME_ADDR = a;
    FRAME_LEN  = l;
    FRAME_VLD  = 1'b1;
    @(posedge CLK);
    #1;
    FRAME_VLD  = 1'b0;
  endtask

  task automatic run_frame(input logic [AW-1:0] a, input logic [LW-1:0] l,
                           input int ew, input logic [RW-1:0] er);
    int r0, t, n;
    logic [DW-1:0] m;
    logic          f, lw;
    beats.delete();
    rd_addrs.delete();
    r0 = rel_count;
    commit(a, l);
    t = 0;
    while (rel_count == r0 && t < 2000) begin
      @(posedge CLK);
      t++;
    end
    @(negedge CLK);
    chk("rel_seen", 64'(rel_count - r0), 64'd1);
    if (rel_count == r0) begin
      recover();
    end else begin
      exp_frames++;
      chk("rel_words", 64'(last_rel_words), 64'(ew));
      chk("frames_sent", 64'(FRAMES_SENT), 64'(exp_frames));
      chk("beat_count", 64'(beats.size()), 64'(ew));
      chk("read_count", 64'(rd_addrs.size()), 64'(ew));
      n = (beats.size() < ew) ? beats.size() : ew;
      for (int i = 0; i < n; i++) begin
        f  = (i == 0);
        lw = (i == ew - 1);
        m  = lw ? (64'hFFFF_FFFF_FFFF_FFFF >> (8 * (7 - int'(er)))) : 64'hFFFF_FFFF_FFFF_FFFF;
        chk("data", beats[i].data & m, mem[(int'(a) + i) % BS] & m);
        chk("ctl", 64'(ctl_of(beats[i])), 64'({f, f, lw, lw, (lw ? er : 3'b111)}));
      end
      n = (rd_addrs.size() < ew) ? rd_addrs.size() : ew;
      for (int i = 0; i < n; i++) begin
        chk("rd_addr", 64'(rd_addrs[i]), 64'((int'(a) + i) % BS));
      end
    end
  endtask

  initial begin
    int     r0, t, ew;
    logic [AW-1:0] ra;
    logic [LW-1:0] rl;
    longint sum_exp, sum0;

    for (int i = 0; i < BS; i++) mem[i] = {$urandom, $urandom};

    //         addr     len      words rem   stall
    vecs[0] = '{9'd0,   16'd20,   3,   3'd3, 1'b0};
    vecs[1] = '{9'd510, 16'd32,   4,   3'd7, 1'b0};
    vecs[2] = '{9'd5,   16'd64,   8,   3'd7, 1'b1};
    vecs[3] = '{9'd100, 16'd1,    1,   3'd0, 1'b0};
    vecs[4] = '{9'd300, 16'd9,    2,   3'd0, 1'b1};
    vecs[5] = '{9'd511, 16'd16,   2,   3'd7, 1'b1};
    vecs[6] = '{9'd200, 16'd1500, 188, 3'd3, 1'b1};

    RESET = 1'b1; FRAME_VLD = 1'b0; FRAME_ADDR = '0; FRAME_LEN = '0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("rst_frame_rdy", 64'(FRAME_RDY), 64'd0);
    chk("rst_buf_rd", 64'(BUF_RD), 64'd0);
    chk("rst_buf_addr", 64'(BUF_ADDR), 64'd0);
    chk("rst_src_rdy_n", 64'(TX_SRC_RDY_N), 64'd1);
    chk("rst_delims_n", 64'({TX_SOF_N, TX_SOP_N, TX_EOP_N, TX_EOF_N}), 64'hF);
    chk("rst_tx_data", TX_DATA, 64'd0);
    chk("rst_tx_rem", 64'(TX_REM), 64'd0);
    chk("rst_rel", 64'({REL_VLD, REL_WORDS}), 64'd0);
    chk("rst_busy", 64'(BUSY), 64'd0);
    chk("rst_frames", 64'(FRAMES_SENT), 64'd0);
    @(posedge CLK); #1; RESET = 1'b0;
    @(negedge CLK);
    chk("post_rst_rdy", 64'(FRAME_RDY), 64'd1);

    for (int v = 0; v < 7; v++) begin
      stall_en = vecs[v].stall;
      run_frame(vecs[v].addr, vecs[v].len, vecs[v].words, vecs[v].rem);
    end

    // len=0 immediately followed by a single-word frame.
    stall_en = 1'b0;
    repeat (2) @(posedge CLK);
    beats.delete(); rd_addrs.delete();
    r0 = rel_count;
    @(negedge CLK);
    chk("b2b_rdy", 64'(FRAME_RDY), 64'd1);
    FRAME_ADDR = 9'd50; FRAME_LEN = 16'd0; FRAME_VLD = 1'b1;
    @(posedge CLK); #1;
    FRAME_ADDR = 9'd60; FRAME_LEN = 16'd8;
    @(negedge CLK);
    chk("zero_rel_vld", 64'(REL_VLD), 64'd1);
    chk("zero_rel_words", 64'(REL_WORDS), 64'd0);
    chk("zero_src_rdy_n", 64'(TX_SRC_RDY_N), 64'd1);
    chk("zero_rdy_again", 64'(FRAME_RDY), 64'd1);
    @(posedge CLK); #1; FRAME_VLD = 1'b0;
    @(negedge CLK);
    chk("lat1_src_rdy_n", 64'(TX_SRC_RDY_N), 64'd1);
    chk("lat1_buf_rd", 64'({BUF_RD, BUF_ADDR}), 64'({1'b1, 9'd60}));
    chk("lat1_busy", 64'(BUSY), 64'd1);
    @(negedge CLK);
    chk("lat2_src_rdy_n", 64'(TX_SRC_RDY_N), 64'd1);
    @(negedge CLK);
    chk("lat3_src_rdy_n", 64'(TX_SRC_RDY_N), 64'd0);
    chk("single_delims_n", 64'({TX_SOF_N, TX_SOP_N, TX_EOP_N, TX_EOF_N}), 64'h0);
    chk("single_rem", 64'(TX_REM), 64'd7);
    chk("single_data", TX_DATA, mem[60]);
    t = 0;
    while (rel_count < r0 + 2 && t < 50) begin @(posedge CLK); t++; end
    @(negedge CLK);
    exp_frames++;
    chk("b2b_rel_count", 64'(rel_count - r0), 64'd2);
    chk("b2b_rel_words", 64'(last_rel_words), 64'd1);
    chk("b2b_frames", 64'(FRAMES_SENT), 64'(exp_frames));
    chk("b2b_beats", 64'(beats.size()), 64'd1);

    // Reset in the middle of a 6-word frame.
    beats.delete(); rd_addrs.delete();
    r0 = rel_count;
    commit(9'd0, 16'd48);
    t = 0;
    while (beats.size() < 2 && t < 50) begin @(posedge CLK); t++; end
    chk("mid_two_beats", 64'(beats.size() >= 2), 64'd1);
    #1; RESET = 1'b1;
    @(negedge CLK);
    chk("mid_rst_rdy_now", 64'(FRAME_RDY), 64'd0);
    @(posedge CLK);
    @(negedge CLK);
    chk("mid_src_rdy_n", 64'(TX_SRC_RDY_N), 64'd1);
    chk("mid_frame_rdy", 64'(FRAME_RDY), 64'd0);
    chk("mid_rel_vld", 64'(REL_VLD), 64'd0);
    chk("mid_busy", 64'(BUSY), 64'd0);
    @(posedge CLK); #1; RESET = 1'b0;
    exp_frames = 0;
    @(negedge CLK);
    chk("mid_rdy_after", 64'(FRAME_RDY), 64'd1);
    chk("mid_no_rel", 64'(rel_count - r0), 64'd0);
    chk("mid_frames", 64'(FRAMES_SENT), 64'd0);
    run_frame(9'd40, 16'd16, 2, 3'd7);

    // Random frames with random stalls.
    stall_en = 1'b1;
    sum_exp = 0;
    sum0 = rel_sum;
    for (int k = 0; k < 100; k++) begin
      ra = AW'($urandom_range(0, BS - 1));
      rl = LW'($urandom_range(1, 1500));
      ew = (int'(rl) + 7) / 8;
      sum_exp += longint'(ew);
      run_frame(ra, rl, ew, RW'((int'(rl) - 1) % 8));
    end
    chk("rel_sum", 64'(rel_sum - sum0), 64'(sum_exp));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
